// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Purpose  : Shared types and widths for the req/ack link master and slave.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        M_IDLE         = 3'd0,
        M_REQ          = 3'd1,
        M_WAIT_ACK_LOW = 3'd2,
        M_DONE         = 3'd3,
        M_HALT         = 3'd4
    } master_state_t;

    typedef enum logic [1:0] {
        S_WAIT_REQ     = 2'd0,
        S_ACK          = 2'd1,
        S_WAIT_REQ_LOW = 2'd2
    } slave_state_t;

endpackage : link_pkg
`default_nettype wire

// File: rtl/link_master.sv
`default_nettype none
// ============================================================================
// Module   : link_master
// Purpose  : Sender side of the 4-phase link. Sends NUM_BYTES bytes, one per
//            handshake, then pulses done. Optional macro LINK_REPEAT_EN makes
//            the burst repeat instead of halting.
// Revision : 1.0 - initial release
// ============================================================================
module link_master
    import link_pkg::*;
#(
    parameter int                NUM_BYTES = 4,
    parameter logic [DATA_W-1:0] BASE_DATA = 8'hA0
) (
    input  logic              clk,
    input  logic              rst,      // active-low, asynchronous
    input  logic              i_ack,
    output logic              o_req,
    output logic [DATA_W-1:0] o_data,
    output logic              o_done
);

    localparam logic [DATA_W-1:0] c_LAST_IDX = DATA_W'(NUM_BYTES - 1);

    master_state_t     r_state;
    logic [DATA_W-1:0] r_idx;
    logic              r_req;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic [DATA_W-1:0] w_next_idx;

    assign w_next_idx = r_idx + 8'd1;

    // Sender FSM: raise req with the indexed byte, drop it on ack, wait for
    // ack low before either the next byte or the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= M_IDLE;
            r_idx   <= '0;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                M_IDLE: begin
                    r_req   <= 1'b1;
                    r_data  <= BASE_DATA + r_idx;
                    r_state <= M_REQ;
                end
                M_REQ: begin
                    if (i_ack) begin
                        r_req   <= 1'b0;
                        r_state <= M_WAIT_ACK_LOW;
                    end
                end
                M_WAIT_ACK_LOW: begin
                    // Waiting for ack low keeps a lingering ack from
                    // being taken as acceptance of the following byte.
                    if (!i_ack) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= M_DONE;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_req   <= 1'b1;
                            r_data  <= BASE_DATA + w_next_idx;
                            r_state <= M_REQ;
                        end
                    end
                end
                M_DONE: begin
                    r_done <= 1'b0;
`ifdef LINK_REPEAT_EN
                    r_idx   <= '0;
                    r_state <= M_IDLE;
`else
                    r_state <= M_HALT;
`endif
                end
                M_HALT: begin
                    r_req <= 1'b0;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= M_HALT;
                end
            endcase
        end
    end

    assign o_req  = r_req;
    assign o_data = r_data;
    assign o_done = r_done;

endmodule : link_master
`default_nettype wire

// File: rtl/link_slave.sv
`default_nettype none
// ============================================================================
// Module   : link_slave
// Purpose  : Receiver side of the 4-phase link. Latches each byte on req,
//            holds ack for ACK_HOLD cycles, counts accepted bytes (saturating).
//            With LINK_REPEAT_EN defined the count clears on the done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module link_slave
    import link_pkg::*;
#(
    parameter int ACK_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,      // active-low, asynchronous
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
`ifdef LINK_REPEAT_EN
    input  logic              i_done,
`endif
    output logic              o_ack,
    output logic [DATA_W-1:0] o_last_byte,
    output logic [DATA_W-1:0] o_rx_count
);

    localparam int                  c_HOLD_W    = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(ACK_HOLD - 1);

    slave_state_t      r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic              r_ack;
    logic [DATA_W-1:0] r_last_byte;
    logic [DATA_W-1:0] r_rx_count;

    // Receiver FSM: accept a byte on req, hold ack for a fixed count, then
    // wait for req to drop before re-arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_WAIT_REQ;
            r_hold      <= '0;
            r_ack       <= 1'b0;
            r_last_byte <= '0;
            r_rx_count  <= '0;
        end else begin
`ifdef LINK_REPEAT_EN
            // The done pulse marks the end of a burst; the next burst
            // counts from zero again.
            if (i_done) begin
                r_rx_count <= '0;
            end
`endif
            case (r_state)
                S_WAIT_REQ: begin
                    if (i_req) begin
                        r_last_byte <= i_data;
                        if (r_rx_count != 8'hFF) begin
                            r_rx_count <= r_rx_count + 8'd1;
                        end
                        r_ack   <= 1'b1;
                        r_hold  <= c_HOLD_LOAD;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (r_hold == '0) begin
                        r_ack   <= 1'b0;
                        r_state <= S_WAIT_REQ_LOW;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                S_WAIT_REQ_LOW: begin
                    if (!i_req) begin
                        r_state <= S_WAIT_REQ;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= S_WAIT_REQ;
                end
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_last_byte = r_last_byte;
    assign o_rx_count  = r_rx_count;

endmodule : link_slave
`default_nettype wire

// File: rtl/req_ack_link.sv
`default_nettype none
// ============================================================================
// Module   : req_ack_link
// Purpose  : Self-contained 4-phase req/ack link: a master that sends a burst
//            of NUM_BYTES bytes and a slave that receives them. Handshake is
//            exported for monitoring. Optional macro LINK_REPEAT_EN repeats
//            the burst indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module req_ack_link
    import link_pkg::*;
#(
    parameter int                NUM_BYTES = 4,
    parameter int                ACK_HOLD  = 2,
    parameter logic [DATA_W-1:0] BASE_DATA = 8'hA0
) (
    input  logic              clk,
    input  logic              rst,        // active-low, asynchronous
    output logic              req,
    output logic              ack,
    output logic [DATA_W-1:0] data,
    output logic              done,
    output logic [DATA_W-1:0] last_byte,
    output logic [DATA_W-1:0] rx_count
);

    link_master #(
        .NUM_BYTES (NUM_BYTES),
        .BASE_DATA (BASE_DATA)
    ) u_master (
        .clk    (clk),
        .rst    (rst),
        .i_ack  (ack),
        .o_req  (req),
        .o_data (data),
        .o_done (done)
    );

    link_slave #(
        .ACK_HOLD (ACK_HOLD)
    ) u_slave (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_data      (data),
`ifdef LINK_REPEAT_EN
        .i_done      (done),
`endif
        .o_ack       (ack),
        .o_last_byte (last_byte),
        .o_rx_count  (rx_count)
    );

endmodule : req_ack_link
`default_nettype wire

// File: tb/tb_req_ack_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_ack_link
// Purpose  : Self-checking bench for req_ack_link (default parameters plus an
//            ACK_HOLD=4 / NUM_BYTES=3 instance). Follows LINK_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_ack_link;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       req, ack, done;
    logic [7:0] data, last_byte, rx_count;
    logic       req2, ack2, done2;
    logic [7:0] data2, last_byte2, rx_count2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    req_ack_link dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ack       (ack),
        .data      (data),
        .done      (done),
        .last_byte (last_byte),
        .rx_count  (rx_count)
    );

    req_ack_link #(
        .NUM_BYTES (3),
        .ACK_HOLD  (4),
        .BASE_DATA (8'hA0)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .req       (req2),
        .ack       (ack2),
        .data      (data2),
        .done      (done2),
        .last_byte (last_byte2),
        .rx_count  (rx_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs after each edge following reset release.
    typedef struct {
        logic       req;
        logic       ack;
        logic [7:0] data;
        logic       done;
        logic [7:0] rx;
        logic [7:0] last;
    } vec_t;

    vec_t vecs [1:19];

    task automatic setv(input int i, input logic rq, input logic ak, input logic [7:0] d,
                        input logic dn, input logic [7:0] rx, input logic [7:0] lb);
        vecs[i].req  = rq;
        vecs[i].ack  = ak;
        vecs[i].data = d;
        vecs[i].done = dn;
        vecs[i].rx   = rx;
        vecs[i].last = lb;
    endtask

    // Protocol monitor on the default instance, sampled on the falling edge.
    logic       m_valid = 1'b0;
    logic       m_req, m_ack, m_rise;
    logic [7:0] m_data;
    int         m_run = 0;

    always @(negedge clk) begin
        if (rst && m_valid) begin
            if (m_req && req)
                check("data_stable_while_req", {24'd0, data}, {24'd0, m_data});
            if (!m_ack && ack)
                check("ack_rise_needs_req", {31'd0, req}, 32'd1);
            if (m_rise)
                check("req_fall_one_edge_after_ack", {31'd0, req}, 32'd0);
            if (m_ack && !ack)
                check("ack_pulse_width", m_run, 32'd2);
        end
        if (!rst) begin
            m_valid = 1'b0;
            m_run   = 0;
            m_rise  = 1'b0;
        end else begin
            m_rise  = !m_ack && ack && m_valid;
            m_run   = ack ? m_run + 1 : 0;
            m_valid = 1'b1;
        end
        m_req  = req;
        m_ack  = ack;
        m_data = data;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;

        //          edge req ack data  done rx    last
        setv( 1, 1, 0, 8'hA0, 0, 8'd0, 8'h00);
        setv( 2, 1, 1, 8'hA0, 0, 8'd1, 8'hA0);
        setv( 3, 0, 1, 8'hA0, 0, 8'd1, 8'hA0);
        setv( 4, 0, 0, 8'hA0, 0, 8'd1, 8'hA0);
        setv( 5, 1, 0, 8'hA1, 0, 8'd1, 8'hA0);
        setv( 6, 1, 1, 8'hA1, 0, 8'd2, 8'hA1);
        setv( 7, 0, 1, 8'hA1, 0, 8'd2, 8'hA1);
        setv( 8, 0, 0, 8'hA1, 0, 8'd2, 8'hA1);
        setv( 9, 1, 0, 8'hA2, 0, 8'd2, 8'hA1);
        setv(10, 1, 1, 8'hA2, 0, 8'd3, 8'hA2);
        setv(11, 0, 1, 8'hA2, 0, 8'd3, 8'hA2);
        setv(12, 0, 0, 8'hA2, 0, 8'd3, 8'hA2);
        setv(13, 1, 0, 8'hA3, 0, 8'd3, 8'hA2);
        setv(14, 1, 1, 8'hA3, 0, 8'd4, 8'hA3);
        setv(15, 0, 1, 8'hA3, 0, 8'd4, 8'hA3);
        setv(16, 0, 0, 8'hA3, 0, 8'd4, 8'hA3);
        setv(17, 0, 0, 8'hA3, 1, 8'd4, 8'hA3);
`ifdef LINK_REPEAT_EN
        setv(18, 0, 0, 8'hA3, 0, 8'd0, 8'hA3);
        setv(19, 1, 0, 8'hA0, 0, 8'd0, 8'hA3);
`else
        setv(18, 0, 0, 8'hA3, 0, 8'd4, 8'hA3);
        setv(19, 0, 0, 8'hA3, 0, 8'd4, 8'hA3);
`endif

        // Reset state of both instances.
        #1;
        check("reset_state", {5'd0, req, ack, data, done, rx_count, last_byte}, 32'd0);
        check("reset_state_2", {5'd0, req2, ack2, data2, done2, rx_count2, last_byte2}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        // Main burst: compare every edge against the table.
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("edge%0d", e),
                  {5'd0, req, ack, data, done, rx_count, last_byte},
                  {5'd0, vecs[e].req, vecs[e].ack, vecs[e].data, vecs[e].done, vecs[e].rx, vecs[e].last});
            if (e == 5)  check("h4_ack_still_high_e5", {31'd0, ack2}, 32'd1);
            if (e == 6)  check("h4_ack_low_e6", {31'd0, ack2}, 32'd0);
            if (e == 7)  check("h4_byte1_req_e7", {23'd0, req2, data2}, {23'd0, 1'b1, 8'hA1});
            if (e == 18) check("h4_done_low_e18", {31'd0, done2}, 32'd0);
            if (e == 19) check("h4_done_e19", {15'd0, done2, rx_count2, last_byte2},
                               {15'd0, 1'b1, 8'd3, 8'hA2});
        end

`ifdef LINK_REPEAT_EN
        // Second burst restarts the count with byte A0.
        @(posedge clk);
        #1;
        check("repeat_second_burst_first_byte", {15'd0, ack, rx_count, last_byte},
              {15'd0, 1'b1, 8'd1, 8'hA0});
`else
        // Halted: req and done stay low for 50 cycles.
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (req || done) seen++;
        end
        check("halt_quiet_50", seen, 32'd0);
`endif

        // Mid-burst reset while byte 2 is being acknowledged.
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midburst_byte2_inflight", {22'd0, req, ack, data}, {22'd0, 1'b1, 1'b1, 8'hA2});
        #1 rst = 1'b0;
        #1;
        check("async_reset_outputs", {5'd0, req, ack, data, done, rx_count, last_byte}, 32'd0);
        check("async_reset_outputs_2", {5'd0, req2, ack2, data2, done2, rx_count2, last_byte2}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("restart_byte0_req", {23'd0, req, data}, {23'd0, 1'b1, 8'hA0});
        @(posedge clk);
        #1;
        check("restart_byte0_accept", {15'd0, ack, rx_count, last_byte}, {15'd0, 1'b1, 8'd1, 8'hA0});

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_req_ack_link
`default_nettype wire
